uio_bus_arbiter: RTL

//  Shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) of the
//  tt_um_k_ziegler27 top among NUM_REQ internal clients. Round-robin

---
 rtl/uio_bus_arbiter_if.sv | 40 ++++
 rtl/uio_bus_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter_if.sv
// Client request/grant bundle plus the uio pad signals of uio_bus_arbiter.
// req_lock exists only when UIO_ARB_LOCK_EN is defined.
interface uio_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic                 ena;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_wr;
  logic [8*NUM_REQ-1:0] req_wdata;
`ifdef UIO_ARB_LOCK_EN
  logic [NUM_REQ-1:0]   req_lock;
`endif
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           rdata;
  logic                 busy;
  logic [7:0]           uio_in;
  logic [7:0]           uio_out;
  logic [7:0]           uio_oe;

`ifdef UIO_ARB_LOCK_EN
  modport master (
    output ena, req, req_wr, req_wdata, req_lock, uio_in,
    input  gnt, ack, rdata, busy, uio_out, uio_oe
  );
  modport slave (
    input  ena, req, req_wr, req_wdata, req_lock, uio_in,
    output gnt, ack, rdata, busy, uio_out, uio_oe
  );
`else
  modport master (
    output ena, req, req_wr, req_wdata, uio_in,
    input  gnt, ack, rdata, busy, uio_out, uio_oe
  );
  modport slave (
    input  ena, req, req_wr, req_wdata, uio_in,
    output gnt, ack, rdata, busy, uio_out, uio_oe
  );
`endif
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bus among NUM_REQ clients, with
// turnaround on direction change. Define UIO_ARB_LOCK_EN to enable locked re-grants.
module uio_bus_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned XFER_CYCLES = 2,
  parameter int unsigned TURN_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  uio_bus_arbiter_if.slave  bus_io
);

  localparam int unsigned IdxW      = $clog2(NUM_REQ);
  localparam logic [15:0] XferLast  = 16'(XFER_CYCLES - 1);
  localparam logic [15:0] TurnLast  = 16'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StTurn, StXfer, StDone} state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic                wr_q, wr_d;
  logic                last_dir_q, last_dir_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic [7:0]          uio_out_q, uio_out_d;
  logic [7:0]          uio_oe_q, uio_oe_d;

  logic                win_valid;
  logic [IdxW-1:0]     win_idx;
  logic [IdxW-1:0]     cand;
  logic [IdxW-1:0]     next_ptr;

`ifdef UIO_ARB_LOCK_EN
  localparam logic [2:0] LockMax = 3'd4;
  logic [2:0] lock_cnt_q, lock_cnt_d;
  logic       relock;

  // Same client may keep the bus for up to LockMax consecutive grants.
  assign relock = bus_io.ena && bus_io.req[idx_q] && bus_io.req_lock[idx_q] &&
                  (lock_cnt_q < LockMax);
`endif

  // Scan from the last candidate down so the first hit at/after ptr wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IdxW'((int'(ptr_q) + i) % NUM_REQ);
      if (bus_io.req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign next_ptr = (int'(idx_q) == int'(NUM_REQ) - 1) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    wr_d       = wr_q;
    last_dir_d = last_dir_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
`ifdef UIO_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus_io.ena && win_valid) begin
          idx_d   = win_idx;
          wr_d    = bus_io.req_wr[win_idx];
          wdata_d = bus_io.req_wdata[8*int'(win_idx) +: 8];
          cnt_d   = '0;
          state_d = (bus_io.req_wr[win_idx] != last_dir_q) ? StTurn : StXfer;
`ifdef UIO_ARB_LOCK_EN
          lock_cnt_d = 3'd1;
`endif
        end
      end
      StTurn: begin
        if (cnt_q == TurnLast) begin
          cnt_d      = '0;
          last_dir_d = wr_q;
          state_d    = StXfer;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StXfer: begin
        if (cnt_q == XferLast) begin
          cnt_d   = '0;
          state_d = StDone;
          if (!wr_q) rdata_d = bus_io.uio_in;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        ptr_d   = next_ptr;
`ifdef UIO_ARB_LOCK_EN
        if (relock) begin
          ptr_d      = ptr_q;
          wr_d       = bus_io.req_wr[idx_q];
          wdata_d    = bus_io.req_wdata[8*int'(idx_q) +: 8];
          cnt_d      = '0;
          lock_cnt_d = lock_cnt_q + 3'd1;
          state_d    = (bus_io.req_wr[idx_q] != last_dir_q) ? StTurn : StXfer;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    // Registered outputs are derived from the next state.
    gnt_d = '0;
    if (state_d == StTurn || state_d == StXfer) gnt_d[idx_d] = 1'b1;
    ack_d = '0;
    if (state_d == StDone) ack_d[idx_d] = 1'b1;
    busy_d    = (state_d != StIdle);
    uio_oe_d  = (state_d == StXfer && wr_d) ? 8'hFF : 8'h00;
    uio_out_d = (state_d == StXfer && wr_d) ? wdata_d : uio_out_q;
`ifdef UIO_ARB_LOCK_EN
    // Keep pads driven through DONE when a locked write follows without turnaround.
    if (state_q == StXfer && state_d == StDone && wr_q && relock && bus_io.req_wr[idx_q]) begin
      uio_oe_d = 8'hFF;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      wr_q       <= 1'b0;
      last_dir_q <= 1'b0;
      wdata_q    <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      uio_out_q  <= '0;
      uio_oe_q   <= '0;
`ifdef UIO_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      wr_q       <= wr_d;
      last_dir_q <= last_dir_d;
      wdata_q    <= wdata_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      uio_out_q  <= uio_out_d;
      uio_oe_q   <= uio_oe_d;
`ifdef UIO_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign bus_io.gnt     = gnt_q;
  assign bus_io.ack     = ack_q;
  assign bus_io.rdata   = rdata_q;
  assign bus_io.busy    = busy_q;
  assign bus_io.uio_out = uio_out_q;
  assign bus_io.uio_oe  = uio_oe_q;

endmodule
